// File: rtl/ldstr_pkg.sv
// ldstr_pkg: shared types and default widths for the load/store initiator.
//   state_t     FSM states IDLE, ISSUE, WAIT, RESP
//   ldstr_cmd_t command fields {is_store, addr, wdata} at the default widths
package ldstr_pkg;
    localparam int LDSTR_ADDR_W = 3;
    localparam int LDSTR_DATA_W = 32;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef struct packed {
        logic                    is_store;
        logic [LDSTR_ADDR_W-1:0] addr;
        logic [LDSTR_DATA_W-1:0] wdata;
    } ldstr_cmd_t;
endpackage

// File: rtl/ldstr_sat_cnt.sv
// ldstr_sat_cnt: saturating up-counter with synchronous clear.
//   clk, rst_n  clock, asynchronous active-low reset
//   inc         count one event (ignored once the count is all-ones)
//   clr         synchronous clear
//   cnt         current count
module ldstr_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && cnt != '1) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/ldstr_initiator.sv
// ldstr_initiator: requester engine for the 8-word load/store memory, one transaction in flight.
//   cmd_*   valid/ready command front end (is_store, addr, wdata)
//   mem_*   one-cycle ren/wen strobe with addr/wdata; mem_en acknowledges, mem_rdata carries load data
//   rsp_*   valid/ready response back end (is_store, rdata, err)
//   load_cnt, store_cnt  saturating counts of completed transactions
// Optional feature: define LDSTR_TIMEOUT_EN to bound WAIT to TMO_CYC cycles and report rsp_err.
module ldstr_initiator
    import ldstr_pkg::*;
#(
    parameter int ADDR_W  = LDSTR_ADDR_W,
    parameter int DATA_W  = LDSTR_DATA_W,
    parameter int TMO_CYC = 8,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_is_store,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_en,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_is_store,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  load_cnt,
    output logic [CNT_W-1:0]  store_cnt
);
    state_t            state, state_nx;
    logic              is_store_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              tmo_hit;
    logic              done;
    logic              inc_ld, inc_st;

`ifdef LDSTR_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;
    // tmo_q counts completed WAIT cycles; the TMO_CYC-th one without an ack ends the wait
    assign tmo_hit = (tmo_q == TMO_W'(TMO_CYC - 1));
    assign rsp_err = err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= (state == WAIT) ? tmo_q + 1'b1 : '0;
            if (state == WAIT && (mem_en || tmo_hit)) err_q <= !mem_en;
        end
    end
`else
    assign tmo_hit = 1'b0 & (TMO_CYC == 0);
    assign rsp_err = 1'b0;
`endif

    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign rsp_is_store = is_store_q;
    assign rsp_rdata    = rdata_q;

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        rsp_valid = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nx = ISSUE;
            end
            ISSUE: begin
                mem_ren  = !is_store_q;
                mem_wen  = is_store_q;
                state_nx = WAIT;
            end
            WAIT: if (mem_en || tmo_hit) state_nx = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                done      = rsp_ready;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // a timed-out transaction completes without being counted
        inc_ld = done && !is_store_q && !rsp_err;
        inc_st = done && is_store_q && !rsp_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            is_store_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && cmd_valid) begin
                is_store_q <= cmd_is_store;
                addr_q     <= cmd_addr;
                wdata_q    <= cmd_wdata;
            end
            if (state == WAIT && (mem_en || tmo_hit)) rdata_q <= (mem_en && !is_store_q) ? mem_rdata : '0;
        end
    end

    ldstr_sat_cnt #(.CNT_W(CNT_W)) u_load_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_ld),
        .clr   (1'b0),
        .cnt   (load_cnt)
    );

    ldstr_sat_cnt #(.CNT_W(CNT_W)) u_store_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_st),
        .clr   (1'b0),
        .cnt   (store_cnt)
    );
endmodule

// File: tb/tb_ldstr_initiator.sv
// tb_ldstr_initiator: directed bench for ldstr_initiator with a behavioural delayed-ack memory.
module tb_ldstr_initiator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_is_store = 1'b0;
    logic [2:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        mem_ren, mem_wen, mem_en;
    logic [2:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_is_store, rsp_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  load_cnt, store_cnt;

    int checks = 0, failures = 0;
    int ren_n = 0, wen_n = 0, both_n = 0, ren_run = 0, ren_max = 0;
    logic [2:0] wen_addr = '0;
    int cyc, ren_snap;

    always #5 clk = ~clk;

    ldstr_initiator #(.ADDR_W(3), .DATA_W(32), .TMO_CYC(8), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_store(cmd_is_store),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_en(mem_en),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_is_store(rsp_is_store),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .load_cnt(load_cnt), .store_cnt(store_cnt)
    );

    // behavioural memory: acks dly cycles after seeing a strobe (dly=0 never acks); spur injects stray acks
    logic [31:0] mem [8];
    int   dly = 1, cnt = 0;
    logic busy = 1'b0, en_m = 1'b0, spur = 1'b0;
    logic [2:0] rd_a = '0;
    assign mem_en = en_m | spur;
    always @(posedge clk) begin
        en_m <= 1'b0;
        if (mem_wen) mem[mem_addr] <= mem_wdata;
        if (mem_ren || mem_wen) begin
            cnt  <= dly;
            busy <= 1'b1;
            rd_a <= mem_addr;
        end else if (busy) begin
            if (cnt == 1) begin
                en_m      <= 1'b1;
                mem_rdata <= mem[rd_a];
                busy      <= 1'b0;
            end else if (cnt > 1) cnt <= cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (mem_ren) ren_n++;
        if (mem_wen) begin
            wen_n++;
            wen_addr = mem_addr;
        end
        if (mem_ren && mem_wen) both_n++;
        ren_run = mem_ren ? ren_run + 1 : 0;
        if (ren_run > ren_max) ren_max = ren_run;
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic st, input logic [2:0] a, input logic [31:0] d, output int c);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_is_store = st; cmd_addr = a; cmd_wdata = d; rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        c = 1;
        while (!rsp_valid && c < 60) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic finish_rsp;
        @(negedge clk) rsp_ready = 1'b1;
        @(negedge clk) rsp_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_cmd_ready", 96'(cmd_ready), 96'd1);
        chk("rst_ctrl", 96'({rsp_valid, mem_ren, mem_wen, rsp_err, rsp_is_store}), 96'd0);
        chk("rst_cnt", 96'({load_cnt, store_cnt}), 96'd0);
        chk("rst_data", 96'({mem_addr, mem_wdata, rsp_rdata}), 96'd0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;

        txn(1'b1, 3'd5, 32'hDEADBEEF, cyc);
        chk("st_latency", 96'(cyc), 96'd4);
        chk("st_rsp", 96'({rsp_valid, rsp_is_store, rsp_err}), 96'b110);
        chk("st_rdata", 96'(rsp_rdata), 96'd0);
        chk("st_strobes", 96'({wen_n[7:0], ren_n[7:0]}), 96'h0100);
        chk("st_wen_addr", 96'(wen_addr), 96'd5);
        finish_rsp();
        chk("st_done", 96'({cmd_ready, rsp_valid, store_cnt, load_cnt}), 96'b10_01_00);

        txn(1'b0, 3'd5, 32'h0, cyc);
        chk("ld_latency", 96'(cyc), 96'd4);
        chk("ld_rdata", 96'(rsp_rdata), 96'hDEADBEEF);
        chk("ld_is_store", 96'(rsp_is_store), 96'd0);
        chk("ld_strobes", 96'({wen_n[7:0], ren_n[7:0]}), 96'h0101);
        finish_rsp();
        chk("ld_cnts", 96'({load_cnt, store_cnt}), 96'b01_01);

        txn(1'b1, 3'd2, 32'h12345678, cyc);
        finish_rsp();
        txn(1'b0, 3'd2, 32'h0, cyc);
        ren_snap = ren_n + wen_n;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_rsp", 96'({rsp_valid, cmd_ready, rsp_rdata}), {62'd0, 2'b10, 32'h12345678});
            chk("hold_no_strobe", 96'(ren_n + wen_n), 96'(ren_snap));
        end
        finish_rsp();
        chk("hold_cnts", 96'({load_cnt, store_cnt}), 96'b10_10);

        dly = 3;
        ren_n = 0;
        ren_max = 0;
        txn(1'b0, 3'd5, 32'h0, cyc);
        chk("dly_latency", 96'(cyc), 96'd6);
        chk("dly_rdata", 96'(rsp_rdata), 96'hDEADBEEF);
        chk("dly_ren_pulse", 96'({ren_n[7:0], ren_max[7:0]}), 96'h0101);
        finish_rsp();
        dly = 1;
        txn(1'b0, 3'd2, 32'h0, cyc);
        finish_rsp();
        chk("ld_sat", 96'(load_cnt), 96'd3);

        @(negedge clk) spur = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("spur_idle", 96'({cmd_ready, rsp_valid}), 96'b10);
        end
        spur = 1'b0;

        for (int i = 0; i < 5; i++) begin
            txn(1'b1, 3'(i), 32'(i), cyc);
            finish_rsp();
        end
        chk("st_sat", 96'(store_cnt), 96'd3);

        dly = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_is_store = 1'b0; cmd_addr = 3'd1;
        @(negedge clk) cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ctrl", 96'({rsp_valid, mem_ren, mem_wen, rsp_err, cmd_ready}), 96'b00001);
        chk("arst_data", 96'({mem_addr, mem_wdata, rsp_rdata, load_cnt, store_cnt}), 96'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("arst_release", 96'({cmd_ready, rsp_valid}), 96'b10);

        dly = 1;
        txn(1'b1, 3'd3, 32'hA5A5A5A5, cyc);
        finish_rsp();
        chk("post_rst_store", 96'({load_cnt, store_cnt, rsp_err}), 96'b00_01_0);
`ifdef LDSTR_TIMEOUT_EN
        dly = 0;
        txn(1'b0, 3'd3, 32'h0, cyc);
        chk("tmo_latency", 96'(cyc), 96'd10);
        chk("tmo_rsp", 96'({rsp_valid, rsp_err, rsp_rdata}), {62'd0, 2'b11, 32'h0});
        finish_rsp();
        chk("tmo_cnts", 96'({load_cnt, store_cnt}), 96'b00_01);
        dly = 1;
`endif
        chk("never_both", 96'(both_n), 96'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
